butterfly_dit: RTL and testbench
================================

// Module: butterfly_dit
// PURPOSE
//  Radix-2 decimation-in-time FFT butterfly on signed fixed-point complex data.
//  Computes out1 = in1 + W*in2 and out2 = in1 - W*in2.
//  Instantiated N/2 times per stage of the fft_16_dit datapath; the twiddle W
//  comes from the twiddle ROM.
//  One registered pipeline stage with a valid flag.
// PARAMETERS
//  DATA_WIDTH  16  width of each real/imag word, two's complement
//  Q           8   fractional bits of all operands; twiddle 1.0 = 2**Q
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           operands valid this cycle
//  in1_r      in   DATA_WIDTH  upper input, real
//  in1_i      in   DATA_WIDTH  upper input, imag
//  in2_r      in   DATA_WIDTH  lower input, real
//  in2_i      in   DATA_WIDTH  lower input, imag
//  w_r        in   DATA_WIDTH  twiddle, real
//  w_i        in   DATA_WIDTH  twiddle, imag
//  out1_r     out  DATA_WIDTH  in1 + W*in2, real
//  out1_i     out  DATA_WIDTH  in1 + W*in2, imag
//  out2_r     out  DATA_WIDTH  in1 - W*in2, real
//  out2_i     out  DATA_WIDTH  in1 - W*in2, imag
//  out_valid  out  1           outputs valid
// BEHAVIOUR
//  - Reset (rst_n=0, async): all out* regs and out_valid = 0 immediately.
//    Release is synchronous to clk. Reset mid-stream discards the in-flight result.
//  - Latency: exactly 1 clk. out_valid(t+1) = in_valid(t).
//  - Output registers load only when in_valid=1; otherwise they hold.
//  - Throughput 1/cycle. No backpressure, no stall.
//  - Complex product, exact 2*DATA_WIDTH+1-bit signed:
//    pr = in2_r*w_r - in2_i*w_i ; pi = in2_r*w_i + in2_i*w_r.
//  - Scaling: t_r = pr >>> Q, t_i = pi >>> Q (arithmetic shift = floor, no rounding).
//  - Sums are computed at DATA_WIDTH+2 bits: in1 +/- t, with in1 sign-extended.
//  - Narrowing to DATA_WIDTH: keep the low DATA_WIDTH bits (two's-complement wrap),
//    unless BUTTERFLY_SAT_EN is defined.
//  - The 4 outputs are independent. Overflow in one output does not affect the others.
// CONFIGURATION
//  BUTTERFLY_SAT_EN defined:
//    narrowing saturates to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1];
//    t_r/t_i also saturate before the add.
//  BUTTERFLY_SAT_EN undefined: wrap as above. No other difference, same latency.
// STRUCTURE
//  - Package fft_pkg holds:
//    DATA_WIDTH and Q defaults;
//    sat_narrow() function;
//    twiddle constants for N=16 (W^k = exp(-j*2*pi*k/16) in Q format).
//  - One sub-module fft_cmul: combinational complex multiply plus >>>Q,
//    output DATA_WIDTH+1 bits.
//  - butterfly_dit holds the add/sub, narrowing and output registers.
// TESTING (DATA_WIDTH=16, Q=8)
//  - W=1 (0x0100, 0x0000), in1=(0x0100,0), in2=(0x0080,0)
//    -> next cycle out1=(0x0180,0), out2=(0x0080,0), out_valid=1.
//  - W=-j (0x0000, 0xFF00), in1=(0x0100,0), in2=(0x0100,0)
//    -> out1=(0x0100,0xFF00), out2=(0x0100,0x0100).
//  - Floor: W=(0x0080,0), in1=0, in2=(0x0001,0) -> out1_r=0x0000;
//    in2=(0xFFFF,0) -> out1_r=0xFFFF, out2_r=0x0001.
//  - Overflow: W=1, in1=(0x7F00,0), in2=(0x0200,0) -> out2_r=0x7D00 in both modes;
//    out1_r=0x8100 without BUTTERFLY_SAT_EN, 0x7FFF with it.
//  - Valid/hold: in_valid=0 with new operands -> outputs unchanged, out_valid=0.
//    Back-to-back valid vectors -> one result per cycle.
//  - Reset: assert rst_n=0 mid-stream between clk edges
//    -> all outputs and out_valid read 0 before the next edge.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - Shared FFT defaults, narrowing helpers and N=16 twiddle constants.
package fft_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_Q          = 8;
    localparam int TW_N           = 16;

    // W^k = exp(-j*2*pi*k/16) for k = 0..7, Q8, rounded to nearest
    localparam logic signed [DEF_DATA_WIDTH-1:0] TW_R [TW_N/2] = '{
        16'sd256, 16'sd237, 16'sd181, 16'sd98, 16'sd0, -16'sd98, -16'sd181, -16'sd237
    };
    localparam logic signed [DEF_DATA_WIDTH-1:0] TW_I [TW_N/2] = '{
        16'sd0, -16'sd98, -16'sd181, -16'sd237, -16'sd256, -16'sd237, -16'sd181, -16'sd98
    };

    // Clamp a signed value into the range of a width-bit two's-complement word.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // Keep the low width bits and re-sign-extend them (two's-complement wrap).
    function automatic logic signed [63:0] wrap_narrow(input logic signed [63:0] x,
                                                       input int width);
        return (x <<< (64 - width)) >>> (64 - width);
    endfunction

endpackage

// File: rtl/butterfly_dit_if.sv
// rtl/butterfly_dit_if.sv - Operand/result bundle of the radix-2 DIT butterfly.
interface butterfly_dit_if #(
    parameter int DATA_WIDTH = fft_pkg::DEF_DATA_WIDTH
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in1_r;
    logic signed [DATA_WIDTH-1:0] in1_i;
    logic signed [DATA_WIDTH-1:0] in2_r;
    logic signed [DATA_WIDTH-1:0] in2_i;
    logic signed [DATA_WIDTH-1:0] w_r;
    logic signed [DATA_WIDTH-1:0] w_i;
    logic signed [DATA_WIDTH-1:0] out1_r;
    logic signed [DATA_WIDTH-1:0] out1_i;
    logic signed [DATA_WIDTH-1:0] out2_r;
    logic signed [DATA_WIDTH-1:0] out2_i;
    logic                         out_valid;

    modport master (
        output in_valid, in1_r, in1_i, in2_r, in2_i, w_r, w_i,
        input  out1_r, out1_i, out2_r, out2_i, out_valid
    );

    modport slave (
        input  in_valid, in1_r, in1_i, in2_r, in2_i, w_r, w_i,
        output out1_r, out1_i, out2_r, out2_i, out_valid
    );
endinterface

// File: rtl/fft_cmul.sv
// rtl/fft_cmul.sv - Combinational complex multiply by twiddle, floor-scaled by 2**Q.
// BUTTERFLY_SAT_EN saturates the scaled product instead of wrapping it.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int Q          = DEF_Q
) (
    input  logic signed [DATA_WIDTH-1:0] a_r,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] w_r,
    input  logic signed [DATA_WIDTH-1:0] w_i,
    output logic signed [DATA_WIDTH:0]   t_r,
    output logic signed [DATA_WIDTH:0]   t_i
);
    localparam int PW = 2 * DATA_WIDTH + 1;

    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;

    // Exact products: operands sign-extended to the full product width first
    assign pr = PW'(a_r) * PW'(w_r) - PW'(a_i) * PW'(w_i);
    assign pi = PW'(a_r) * PW'(w_i) + PW'(a_i) * PW'(w_r);

`ifdef BUTTERFLY_SAT_EN
    assign t_r = (DATA_WIDTH + 1)'(sat_narrow(64'(pr >>> Q), DATA_WIDTH + 1));
    assign t_i = (DATA_WIDTH + 1)'(sat_narrow(64'(pi >>> Q), DATA_WIDTH + 1));
`else
    assign t_r = (DATA_WIDTH + 1)'(wrap_narrow(64'(pr >>> Q), DATA_WIDTH + 1));
    assign t_i = (DATA_WIDTH + 1)'(wrap_narrow(64'(pi >>> Q), DATA_WIDTH + 1));
`endif

endmodule

// File: rtl/butterfly_dit.sv
// rtl/butterfly_dit.sv - Radix-2 DIT butterfly, one registered stage with valid flag.
// BUTTERFLY_SAT_EN selects saturating narrowing of the outputs (default: wrap).
module butterfly_dit
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int Q          = DEF_Q
) (
    input  logic          clk,
    input  logic          rst_n,
    butterfly_dit_if.slave bus
);
    localparam int DW = DATA_WIDTH;

    logic signed [DW:0]   t_r;
    logic signed [DW:0]   t_i;
    logic signed [DW+1:0] s1_r;
    logic signed [DW+1:0] s1_i;
    logic signed [DW+1:0] s2_r;
    logic signed [DW+1:0] s2_i;

    logic signed [DW-1:0] out1_r_q;
    logic signed [DW-1:0] out1_i_q;
    logic signed [DW-1:0] out2_r_q;
    logic signed [DW-1:0] out2_i_q;
    logic                 out_valid_q;

    fft_cmul #(
        .DATA_WIDTH (DW),
        .Q          (Q)
    ) u_cmul (
        .a_r (bus.in2_r),
        .a_i (bus.in2_i),
        .w_r (bus.w_r),
        .w_i (bus.w_i),
        .t_r (t_r),
        .t_i (t_i)
    );

    // Two guard bits: neither sum nor difference can overflow before narrowing
    assign s1_r = (DW + 2)'(bus.in1_r) + (DW + 2)'(t_r);
    assign s1_i = (DW + 2)'(bus.in1_i) + (DW + 2)'(t_i);
    assign s2_r = (DW + 2)'(bus.in1_r) - (DW + 2)'(t_r);
    assign s2_i = (DW + 2)'(bus.in1_i) - (DW + 2)'(t_i);

    function automatic logic signed [DW-1:0] narrow(input logic signed [DW+1:0] x);
`ifdef BUTTERFLY_SAT_EN
        return DW'(sat_narrow(64'(x), DW));
`else
        return DW'(wrap_narrow(64'(x), DW));
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_r_q    <= '0;
            out1_i_q    <= '0;
            out2_r_q    <= '0;
            out2_i_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out1_r_q <= narrow(s1_r);
                out1_i_q <= narrow(s1_i);
                out2_r_q <= narrow(s2_r);
                out2_i_q <= narrow(s2_i);
            end
        end
    end

    assign bus.out1_r    = out1_r_q;
    assign bus.out1_i    = out1_i_q;
    assign bus.out2_r    = out2_r_q;
    assign bus.out2_i    = out2_i_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_butterfly_dit.sv
// tb/tb_butterfly_dit.sv - Self-checking bench for butterfly_dit (honours BUTTERFLY_SAT_EN).
module tb_butterfly_dit;
    import fft_pkg::*;

    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    butterfly_dit_if #(.DATA_WIDTH(DW)) bus ();

    butterfly_dit #(
        .DATA_WIDTH (DW),
        .Q          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] e1r = '0, e1i = '0, e2r = '0, e2i = '0;
    logic          ev  = 1'b0;
    bit            cmp_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic longint clampw(input longint x, input int w);
        longint lim;
        lim = longint'(1) << (w - 1);
        if (x > lim - 1) return lim - 1;
        if (x < -lim)    return -lim;
        return x;
    endfunction

    // out1 = in1 + W*in2, out2 = in1 - W*in2, Q8 floor scaling, 16-bit result
    function automatic void bfly(input int a_r, input int a_i, input int b_r, input int b_i,
                                 input int w_r, input int w_i,
                                 output logic [DW-1:0] o1r, output logic [DW-1:0] o1i,
                                 output logic [DW-1:0] o2r, output logic [DW-1:0] o2i);
        longint pr, pi, tr, ti;
        pr = longint'(b_r) * w_r - longint'(b_i) * w_i;
        pi = longint'(b_r) * w_i + longint'(b_i) * w_r;
        tr = pr >>> 8;
        ti = pi >>> 8;
`ifdef BUTTERFLY_SAT_EN
        tr  = clampw(tr, DW + 1);
        ti  = clampw(ti, DW + 1);
        o1r = DW'(clampw(a_r + tr, DW));
        o1i = DW'(clampw(a_i + ti, DW));
        o2r = DW'(clampw(a_r - tr, DW));
        o2i = DW'(clampw(a_i - ti, DW));
`else
        o1r = DW'(a_r + tr);
        o1i = DW'(a_i + ti);
        o2r = DW'(a_r - tr);
        o2i = DW'(a_i - ti);
`endif
    endfunction

    task automatic step(input bit v,
                        input logic signed [DW-1:0] a_r, input logic signed [DW-1:0] a_i,
                        input logic signed [DW-1:0] b_r, input logic signed [DW-1:0] b_i,
                        input logic signed [DW-1:0] w_r, input logic signed [DW-1:0] w_i);
        logic [DW-1:0] o1r, o1i, o2r, o2i;
        bus.in_valid = v;
        bus.in1_r = a_r; bus.in1_i = a_i;
        bus.in2_r = b_r; bus.in2_i = b_i;
        bus.w_r   = w_r; bus.w_i   = w_i;
        @(posedge clk);
        #1;
        ev = v;
        if (v) begin
            bfly(int'(a_r), int'(a_i), int'(b_r), int'(b_i), int'(w_r), int'(w_i),
                 o1r, o1i, o2r, o2i);
            e1r = o1r; e1i = o1i; e2r = o2r; e2i = o2i;
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out1_r"}, bus.out1_r, '0);
        chk({tag, " out1_i"}, bus.out1_i, '0);
        chk({tag, " out2_r"}, bus.out2_r, '0);
        chk({tag, " out2_i"}, bus.out2_i, '0);
        chk({tag, " out_valid"}, DW'(bus.out_valid), '0);
    endtask

    // Model comparison on every cycle outside reset
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("model out1_r", bus.out1_r, e1r);
            chk("model out1_i", bus.out1_i, e1i);
            chk("model out2_r", bus.out2_r, e2r);
            chk("model out2_i", bus.out2_i, e2i);
            chk("model out_valid", DW'(bus.out_valid), DW'(ev));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] m1r, m1i, m2r, m2i;
        logic signed [DW-1:0] r1, r2, r3, r4;

        bus.in_valid = 1'b0;
        bus.in1_r = '0; bus.in1_i = '0; bus.in2_r = '0; bus.in2_i = '0;
        bus.w_r = '0;   bus.w_i = '0;

        #1 rst_n = 1'b0;
        #2 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Pin the model against a hand-computed vector
        bfly(256, 0, 128, 0, 256, 0, m1r, m1i, m2r, m2i);
        chk("pin model out1_r", m1r, 16'h0180);
        chk("pin model out2_r", m2r, 16'h0080);

        step(1, 16'sh0100, 16'sh0000, 16'sh0080, 16'sh0000, 16'sh0100, 16'sh0000);
        chk("w1 out1_r", bus.out1_r, 16'h0180);
        chk("w1 out1_i", bus.out1_i, 16'h0000);
        chk("w1 out2_r", bus.out2_r, 16'h0080);
        chk("w1 out2_i", bus.out2_i, 16'h0000);
        chk("w1 out_valid", DW'(bus.out_valid), 16'd1);

        step(1, 16'sh0100, 16'sh0000, 16'sh0100, 16'sh0000, 16'sh0000, 16'shFF00);
        chk("wmj out1_r", bus.out1_r, 16'h0100);
        chk("wmj out1_i", bus.out1_i, 16'hFF00);
        chk("wmj out2_r", bus.out2_r, 16'h0100);
        chk("wmj out2_i", bus.out2_i, 16'h0100);

        step(1, 16'sh0000, 16'sh0000, 16'sh0001, 16'sh0000, 16'sh0080, 16'sh0000);
        chk("floor pos out1_r", bus.out1_r, 16'h0000);

        step(1, 16'sh0000, 16'sh0000, 16'shFFFF, 16'sh0000, 16'sh0080, 16'sh0000);
        chk("floor neg out1_r", bus.out1_r, 16'hFFFF);
        chk("floor neg out2_r", bus.out2_r, 16'h0001);

        step(1, 16'sh7F00, 16'sh0000, 16'sh0200, 16'sh0000, 16'sh0100, 16'sh0000);
        chk("ovf out2_r", bus.out2_r, 16'h7D00);
        chk("ovf out1_i", bus.out1_i, 16'h0000);
`ifdef BUTTERFLY_SAT_EN
        chk("ovf out1_r", bus.out1_r, 16'h7FFF);
`else
        chk("ovf out1_r", bus.out1_r, 16'h8100);
`endif

        // Invalid cycle with fresh operands: registers hold
        step(0, 16'sh1234, 16'sh5678, 16'sh0100, 16'sh0100, 16'sh0100, 16'sh0000);
        chk("hold out2_r", bus.out2_r, 16'h7D00);
        chk("hold out_valid", DW'(bus.out_valid), 16'd0);

        step(1, 16'sh0000, 16'sh0000, 16'sh0100, 16'sh0000, TW_R[2], TW_I[2]);
        chk("w2 out1_r", bus.out1_r, 16'h00B5);
        chk("w2 out1_i", bus.out1_i, 16'hFF4B);
        chk("w2 out2_r", bus.out2_r, 16'hFF4B);
        chk("w2 out2_i", bus.out2_i, 16'h00B5);

        // Back-to-back valid operands across all twiddles, wide data
        for (int k = 0; k < TW_N / 2; k++) begin
            r1 = DW'($urandom); r2 = DW'($urandom);
            r3 = DW'($urandom); r4 = DW'($urandom);
            step(1, r1, r2, r3, r4, TW_R[k], TW_I[k]);
        end
        for (int k = 0; k < 4; k++) begin
            r1 = DW'($urandom); r2 = DW'($urandom);
            r3 = DW'($urandom); r4 = DW'($urandom);
            step(1, r1, r2, r3, r4, DW'($urandom), DW'($urandom));
        end

        // Reset between edges with a valid operand set pending
        bus.in_valid = 1'b1;
        bus.in1_r = 16'sh0300; bus.in1_i = 16'sh0100;
        bus.in2_r = 16'sh0100; bus.in2_i = 16'sh0000;
        bus.w_r   = 16'sh0100; bus.w_i   = 16'sh0000;
        #2 rst_n = 1'b0;
        #1 chk_zero("async reset");
        ev = 1'b0; e1r = '0; e1i = '0; e2r = '0; e2i = '0;
        @(posedge clk);
        #1 chk_zero("reset held");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 16'sh0300, 16'sh0100, 16'sh0100, 16'sh0000, 16'sh0100, 16'sh0000);
        chk("recover out1_r", bus.out1_r, 16'h0400);
        chk("recover out2_r", bus.out2_r, 16'h0200);
        step(0, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
